spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  FPGA-side SPI master; the opposite end of spi_slave. Shifts WIDTH-bit words
//  out on sdo MSB-first while capturing sdi, one full-duplex word per request.
//  Sends peak/trough results to an external SPI slave, or drives spi_slave in
//  a loopback bench. Frames purely by sck edge count, matching spi_slave framing.
// PARAMETERS
//  WIDTH    32  bits per transfer (>=2)
//  CLK_DIV  4   clk cycles per sck half-period (>=1); sck = clk/(2*CLK_DIV)
// PORTS
//  clk       in   1      system clock; all state on posedge clk
//  reset     in   1      asynchronous, active-high reset
//  tx_data   in   WIDTH  word to transmit; sampled on accept
//  tx_valid  in   1      request a transfer
//  tx_ready  out  1      high only in IDLE; accept = tx_valid & tx_ready at posedge clk
//  rx_data   out  WIDTH  word captured from sdi; held until the next DONE
//  rx_valid  out  1      one-cycle pulse, rx_data valid
//  busy      out  1      high in SHIFT and DONE
//  sck       out  1      serial clock, idles low (mode 0)
//  sdo       out  1      master data out (slave's sdo input)
//  sdi       in   1      master data in (slave's sdi output)
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset asynchronous, active-high.
//  Reset values: state=IDLE, sck=0, sdo=0, rx_data=0, rx_valid=0, busy=0,
//   tx_ready=1 once reset deasserts; divider and bit counters cleared.
//  FSM: IDLE -accept-> SHIFT -last falling edge-> DONE -> IDLE (unconditional).
//  On accept: tx shift reg <= tx_data; sdo <= tx_data[WIDTH-1]; div cnt <= 0.
//  SHIFT: sck low for CLK_DIV cycles, then high for CLK_DIV cycles, WIDTH times.
//   sck rising edge: rx shift reg <= {rx[WIDTH-2:0], sdi}.
//   sck falling edge: sdo <= next lower tx bit; after bit 0, sdo stays bit 0.
//   Exactly WIDTH rising and WIDTH falling sck edges per transfer; no glitches.
//   sck and sdo are registered (no combinational path from inputs).
//  SHIFT lasts exactly 2*CLK_DIV*WIDTH clk cycles; then DONE for 1 cycle:
//   rx_data <= rx shift reg, rx_valid=1. rx_valid high 2*CLK_DIV*WIDTH cycles
//   after the accepting edge. Min spacing between accepts 2*CLK_DIV*WIDTH+2.
//  tx_valid in SHIFT/DONE is ignored (not queued); requester holds it until accept.
//  tx_data changes after accept do not affect the word in flight.
//  Counters: divider $clog2(CLK_DIV)+1 bits, wraps at CLK_DIV-1; bit counter
//   $clog2(WIDTH)+1 bits, counts 0..WIDTH-1 on falling edges.
//  Reset mid-transfer: immediate return to reset values, no rx_valid pulse,
//   partial rx bits discarded. Shared reset also clears spi_slave bit count,
//   keeping both ends frame-aligned.
// CONFIGURATION
//  SPI_MASTER_CS_EN defined: extra output cs_n (1 bit), reset value 1; driven 0
//   exactly during SHIFT (2*CLK_DIV*WIDTH cycles), 1 in IDLE and DONE.
//  Not defined: no cs_n port; framing by sck count only. All else identical.
// TESTING
//  1 Reset: assert reset mid-idle -> sck=0, sdo=0, rx_valid=0, rx_data=0, tx_ready=1.
//  2 WIDTH=32, CLK_DIV=2, sdi looped to sdo, send 0xA5A50F0F -> 32 sck rises,
//    rx_valid 128 cycles after accept, rx_data=0xA5A50F0F, sdo MSB first.
//  3 sdi tied 1 -> rx_data=0xFFFFFFFF; sdi tied 0 -> rx_data=0x00000000.
//  4 tx_valid held, 0x12345678 then 0x9ABCDEF0 -> accepts 130 cycles apart,
//    tx_ready low in between, two rx_valid pulses, words in order.
//  5 reset asserted after 10th sck rise -> sck=0 at once, no rx_valid; next
//    transfer 0xDEADBEEF completes correctly against spi_slave.
//  6 SPI_MASTER_CS_EN, CLK_DIV=1: cs_n low exactly 64 cycles per word, high in DONE.

Source files
------------

// File: rtl/spi_master_if.sv
// spi_master_if: word-level request/response bus between a requester and spi_master.
interface spi_master_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, busy);
    modport slave (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, busy);
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one full-duplex MSB-first WIDTH-bit word per request.
// Optional active-low chip select cs_n when SPI_MASTER_CS_EN is defined.
module spi_master #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    spi_master_if.slave bus,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi
`ifdef SPI_MASTER_CS_EN
    , output logic      cs_n
`endif
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_sr, rx_sr, rx_word;
    logic accept, tick, rise, fall, last;
    assign accept = bus.tx_valid && state == IDLE;
    assign tick   = state == SHIFT && div_cnt == DW'(CLK_DIV - 1);
    assign rise   = tick && !sck;
    assign fall   = tick && sck;
    assign last   = fall && bit_cnt == BW'(WIDTH - 1);
    assign bus.rx_data = rx_word;
`ifdef SPI_MASTER_CS_EN
    assign cs_n = state != SHIFT;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx     = state;
        bus.tx_ready = state == IDLE;
        bus.busy     = state != IDLE;
        bus.rx_valid = state == DONE;
        state_nx     = accept ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_word <= '0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
        end else if (accept) begin
            tx_sr   <= bus.tx_data;
            sdo     <= bus.tx_data[WIDTH-1];
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) sck <= ~sck;
            if (rise) rx_sr <= {rx_sr[WIDTH-2:0], sdi};
            // sdo holds bit 0 after the final falling edge
            if (fall) begin
                tx_sr   <= tx_sr << 1;
                bit_cnt <= bit_cnt + BW'(1);
                if (!last) sdo <= tx_sr[WIDTH-2];
            end
            if (last) rx_word <= rx_sr;
        end
endmodule
